// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/writeback controller for the
// 4-bit datapath. Owns PC, instruction register, result register, zero flag and
// a saturating retired-instruction counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_FETCH  | IR <- instruction at PC
// S_DECODE | jumps/NOP/HALT resolved and retired; ALU ops proceed to EXEC
// S_EXEC   | ALU driven with opcode[2:0], result register captured
// S_WB     | result written to rd, zero flag updated, PC advanced
// S_HALTED | program stopped; done held high until start restarts it
module cpu_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       imem_instr,
  input  logic [3:0]       alu_result,
  output logic [3:0]       imem_addr,
  output logic [1:0]       rf_ra1,
  output logic [1:0]       rf_ra2,
  output logic [1:0]       rf_wa,
  output logic [3:0]       rf_wd,
  output logic             rf_we,
  output logic [2:0]       alu_ctrl,
  output logic             busy,
  output logic             done,
  output logic             zero_flag,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [3:0] OP_JZ   = 4'b1000;
  localparam logic [3:0] OP_JMP  = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t           state_q, state_d;
  logic [3:0]       pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  logic [3:0]       res_q, res_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             is_alu, is_halt, take_jump;
  logic [CNT_W-1:0] cnt_inc;

  // Instruction classification from the held IR; opcodes 00xx are the ALU group.
  assign is_alu    = (ir_q[7:6] == 2'b00);
  assign is_halt   = (ir_q[7:4] == OP_HALT);
  assign take_jump = (ir_q[7:4] == OP_JMP) || ((ir_q[7:4] == OP_JZ) && zero_q);
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers, updated from the next-state process.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= 4'd0;
      ir_q   <= 8'd0;
      res_q  <= 4'd0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      res_q  <= res_d;
      zero_q <= zero_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    res_d   = res_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = 4'd0;
          cnt_d   = '0;
          zero_d  = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = imem_instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_alu) begin
          state_d = S_EXEC;
        end else if (is_halt) begin
          cnt_d   = cnt_inc;
          state_d = S_HALTED;
        end else begin
          cnt_d   = cnt_inc;
          pc_d    = take_jump ? ir_q[3:0] : pc_q + 4'd1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        state_d = S_WB;
      end
      S_WB: begin
        zero_d  = (res_q == 4'd0);
        pc_d    = pc_q + 4'd1;
        cnt_d   = cnt_inc;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control outputs decoded from the registered state; the write enable is
  // killed by reset so an interrupted WB never commits.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    rf_we    = 1'b0;
    alu_ctrl = 3'b000;
    case (state_q)
      S_FETCH, S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy     = 1'b1;
        alu_ctrl = ir_q[6:4];
      end
      S_WB: begin
        busy  = 1'b1;
        rf_we = ~reset;
      end
      S_HALTED: done = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr   = pc_q;
  assign rf_ra1      = ir_q[3:2];
  assign rf_ra2      = ir_q[1:0];
  assign rf_wa       = ir_q[3:2];
  assign rf_wd       = res_q;
  assign zero_flag   = zero_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle fetch/decode/execute/writeback controller for the 4-bit processor datapath. It owns the program counter, the instruction register and a zero flag. It drives the instruction-memory address, the register-file read/write ports and the ALU control, sequencing each 8-bit instruction over 2 or 4 cycles. It replaces the single-cycle PC/control pairing and adds start/busy/done handshaking, conditional and unconditional jumps, HALT, and a retired-instruction counter.

## Interface
- CNT_W, 8, width of retired-instruction counter
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  run request, sampled only in IDLE or HALTED
- imem_instr  in  8  instruction at imem_addr (combinational memory)
- alu_result  in  4  ALU output for current rf_rd1/rf_rd2/alu_ctrl
- imem_addr  out  4  equals PC
- rf_ra1  out  2  IR[3:2] (rd / rs1)
- rf_ra2  out  2  IR[1:0] (rs2)
- rf_wa  out  2  IR[3:2]
- rf_wd  out  4  result register
- rf_we  out  1  register-file write enable
- alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- done  out  1  high (level) in HALTED
- zero_flag  out  1  set when last written-back result == 0
- instr_count  out  CNT_W  retired instructions since start, saturating

## Operation
- ISA: opcode IR[7:4]. 0000 ADD, 0001 SUB, 0010 AND, 0011 OR: rd = rd op rs2. 1000 JZ: if zero_flag then PC = IR[3:0]. 1001 JMP: PC = IR[3:0]. 1111 HALT. All other opcodes are NOP.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
- IDLE: start=1 → PC=0, instr_count=0, zero_flag=0, go FETCH.
- FETCH: IR ← imem_instr; go DECODE.
- DECODE: ALU op → EXEC. JMP, or JZ with zero_flag=1 → PC ← IR[3:0]. JZ with zero_flag=0, or NOP → PC ← PC+1. In all of these, count++ and go FETCH. HALT → count++, PC unchanged, go HALTED.
- EXEC: alu_ctrl = opcode[2:0]; result register ← alu_result; go WB.
- WB: rf_we=1; zero_flag ← (result==0); PC ← PC+1; count++; go FETCH.
- HALTED: start=1 → same action as IDLE start (restart from PC=0).
- alu_ctrl = 000 in all states except EXEC. rf_we = (state==WB) & ~reset.
- Arithmetic: PC is 4-bit, wraps 15→0 silently. instr_count saturates at 2^CNT_W−1. zero_flag is changed only by WB; jumps and NOPs leave it unchanged.
- start while busy is ignored, with no queuing.

## Timing
- Reset values: PC=0, IR=0, result=0, zero_flag=0, instr_count=0, state IDLE. Outputs follow: imem_addr=0, rf_ra1/ra2/wa=0, rf_wd=0, rf_we=0, alu_ctrl=000, busy=0, done=0.
- Reset asserted in any state: IDLE on the next edge, with no register write on that edge (rf_we gated combinationally by reset).
- Start sampled at edge E0 → FETCH during cycle E0..E1.
- Cycle cost: ALU instruction 4 cycles (F,D,E,W). Jump/NOP 2 cycles (F,D). HALT reaches HALTED 2 cycles after its FETCH begins.
- done and busy are registered-state decodes: both change on the edge entering or leaving the state; they are never high together.
- Register-file write occurs on the edge ending WB. An instruction fetched next reads the new value (rf_ra1/ra2 valid from DECODE onward).

## Test plan
- Bench memory {00000001, 00110010, 00010001, 11110000}, bench register file init r0..r3 = 1,2,3,4, start at E0 → three WB writes to r0 of 3, 3, 1. done rises at E14, PC=3, instr_count=4, zero_flag=0.
- {00010000 (SUB r0,r0), 10000101 (JZ 5), NOP×3, 11110000 at addr 5} → r0=0, zero_flag=1, jump taken. Halt with imem_addr=5, instr_count=3, done at E4+2+2=E8.
- Same as above but first instruction 00000001 (r0=3) → JZ not taken, falls through to addr 2. Bench places HALT at 2 → halt at PC=2.
- Memory all NOP (01000000) → imem_addr sequence 0..15,0,1… (wrap). After 600 cycles busy stays 1, instr_count = 255 (saturated).
- Reset asserted for one cycle while state=WB → rf_we=0 that cycle, register file unchanged. State IDLE, all outputs at reset values next cycle.
- start pulsed during EXEC → ignored, no restart. start=1 in HALTED → done falls next edge, PC=0, instr_count=0, program re-executes with identical results.
